sprite_compositor: RTL

Parametrised successor to the single-player pixel painter. Composites NUM_SPRITES sprites over the tile layer (foreground block, half slab) and a programmable background, producing registered 12-bit VGA colour with fixed 2-cycle latency. Sprite state is double-buffered: new state commits only at frame boundaries, via a request/acknowledge handshake. Adds per-sprite blink and a per-frame sprite-0 vs foreground collision flag. Sits between game logic / level ROM and the VGA output pins.

---
 rtl/sprite_compositor.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sprite_compositor.sv
// Composites NUM_SPRITES double-buffered sprites over the tile layer and background.
// Output colour is registered with a fixed two-clock latency from the pixel inputs.
module sprite_compositor #(
    parameter int NUM_SPRITES = 4,
    parameter int SPRITE_SIZE = 32,
    parameter int TILE_SIZE   = 32,
    parameter int Y_OFFSET    = 35,
    parameter int BLINK_BIT   = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      frameStart,
    input  logic                      bright,
    input  logic [9:0]                hCount,
    input  logic [9:0]                vCount,
    input  logic [2:0]                blockType,
    input  logic [11:0]               bgColor,
    input  logic [20*NUM_SPRITES-1:0] spritePos,
    input  logic [12*NUM_SPRITES-1:0] spriteColor,
    input  logic [NUM_SPRITES-1:0]    spriteEn,
    input  logic [NUM_SPRITES-1:0]    spriteBlink,
    input  logic                      updReq,
    output logic                      updAck,
    output logic                      collideFlag,
    output logic [11:0]               rgb
);

    localparam logic [10:0] SPAN = 11'(SPRITE_SIZE - 1);

    logic [NUM_SPRITES-1:0][9:0]  actX;
    logic [NUM_SPRITES-1:0][9:0]  actY;
    logic [NUM_SPRITES-1:0][11:0] actColor;
    logic [NUM_SPRITES-1:0]       actEn;
    logic [NUM_SPRITES-1:0]       actBlink;
    logic                         pending;
    logic [5:0]                   frameCnt;
    logic                         commit;

    logic [NUM_SPRITES-1:0] hitVec;
    logic [11:0]            winColor;
    logic [9:0]             tileDiff;
    logic                   fgNow;
    logic                   slabNow;

    logic [NUM_SPRITES-1:0] s1Hit;
    logic [11:0]            s1Color;
    logic                   s1Fg;
    logic                   s1Slab;
    logic                   s1Bright;
    logic [11:0]            s1Bg;
    logic                   sticky;
    logic                   collideTerm;

    assign commit = frameStart & (pending | updReq);

    always_ff @(posedge clk) begin
        if (reset) begin
            actX     <= '0;
            actY     <= '0;
            actColor <= '0;
            actEn    <= '0;
            actBlink <= '0;
            pending  <= 1'b0;
            updAck   <= 1'b0;
            frameCnt <= '0;
        end else begin
            updAck <= commit;
            if (commit) begin
                for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
                    actX[i]     <= spritePos[20*i+10 +: 10];
                    actY[i]     <= spritePos[20*i +: 10];
                    actColor[i] <= spriteColor[12*i +: 12];
                end
                actEn    <= spriteEn;
                actBlink <= spriteBlink;
                pending  <= 1'b0;
            end else if (updReq) begin
                pending <= 1'b1;
            end
            if (frameStart)
                frameCnt <= frameCnt + 6'd1;
        end
    end

    // 11-bit compares so a sprite near the right or top edge clips instead of wrapping.
    always_comb begin
        hitVec = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            hitVec[i] = actEn[i] && !(actBlink[i] && frameCnt[BLINK_BIT])
                && ({1'b0, hCount} >= {1'b0, actX[i]})
                && ({1'b0, hCount} <= {1'b0, actX[i]} + SPAN)
                && ({1'b0, vCount} <= {1'b0, actY[i]})
                && ({1'b0, vCount} + SPAN >= {1'b0, actY[i]});
        end
    end

    // Scan from the highest index down so the lowest-index hit is the last write.
    always_comb begin
        winColor = '0;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (hitVec[NUM_SPRITES-1-i])
                winColor = actColor[NUM_SPRITES-1-i];
        end
    end

    always_comb begin
        tileDiff = vCount - 10'(Y_OFFSET);
        fgNow    = (blockType == 3'd1);
        slabNow  = (blockType == 3'd2)
                && ((tileDiff & 10'(TILE_SIZE - 1)) < 10'(TILE_SIZE / 2));
    end

    assign collideTerm = s1Hit[0] & s1Fg & s1Bright;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1Hit       <= '0;
            s1Color     <= '0;
            s1Fg        <= 1'b0;
            s1Slab      <= 1'b0;
            s1Bright    <= 1'b0;
            s1Bg        <= '0;
            rgb         <= '0;
            sticky      <= 1'b0;
            collideFlag <= 1'b0;
        end else begin
            s1Hit    <= hitVec;
            s1Color  <= winColor;
            s1Fg     <= fgNow;
            s1Slab   <= slabNow;
            s1Bright <= bright;
            s1Bg     <= bgColor;

            if (!s1Bright)
                rgb <= 12'h000;
            else if (|s1Hit)
                rgb <= s1Color;
            else if (s1Fg)
                rgb <= 12'h00F;
            else if (s1Slab)
                rgb <= 12'h0F0;
            else
                rgb <= s1Bg;

            if (frameStart) begin
                collideFlag <= sticky | collideTerm;
                sticky      <= 1'b0;
            end else begin
                sticky <= sticky | collideTerm;
            end
        end
    end

endmodule
